// File: rtl/ctrl_frame_receiver_if.sv
// Bus bundle for the control-frame receiver: control-RX FIFO read side and picosoc iomem port.
// slave is the receiver's view; master is the FIFO/CPU side.
interface ctrl_frame_receiver_if;
  logic [7:0]  i_fifo_dout;
  logic        i_fifo_del;
  logic [3:0]  i_fifo_port;
  logic        i_fifo_empty;
  logic        o_fifo_rden;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport slave (
    input  i_fifo_dout, i_fifo_del, i_fifo_port, i_fifo_empty,
    output o_fifo_rden,
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );

  modport master (
    output i_fifo_dout, i_fifo_del, i_fifo_port, i_fifo_empty,
    input  o_fifo_rden,
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/ctrl_frame_receiver.sv
// Pulls one control frame at a time from the RX FIFO into a 16x32 buffer,
// exposes it read-only on iomem, and reports status through cfg_do.
module ctrl_frame_receiver (
  input  logic                        clk,
  input  logic                        arst_n,
  ctrl_frame_receiver_if.slave        bus,
  input  logic [3:0]                  cfg_we,
  input  logic [31:0]                 cfg_di,
  output logic [31:0]                 cfg_do
);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DROP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  byte_len_q, byte_len_d;
  logic [3:0]  src_port_q, src_port_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        truncated_q, truncated_d;
  logic        busy_q, busy_d;
  logic        iomem_ready_q, iomem_ready_d;
  logic [31:0] iomem_rdata_q, iomem_rdata_d;
  logic [31:0] ram_q [16];
  logic [31:0] ram_d [16];

  logic rden, w1c, flush, wr_en, iomem_hit;

  assign w1c   = cfg_we[3] & cfg_di[31];
  assign flush = cfg_we[3] & cfg_di[28];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_len_d    = byte_len_q;
    src_port_d    = src_port_q;
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = frame_valid_q;
    truncated_d   = truncated_q;
    busy_d        = busy_q;
    rden          = 1'b0;
    wr_en         = 1'b0;

    // W1C is applied first so a same-edge DONE set overrides it
    if (w1c) begin
      frame_valid_d = 1'b0;
      truncated_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!bus.i_fifo_empty && !frame_valid_q) begin
          state_d = S_RX;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RX: begin
        rden = !bus.i_fifo_empty && !pending_q;
        if (pending_q) begin
          if (!cnt_q[6]) begin
            wr_en      = 1'b1;
            byte_len_d = cnt_q[5:0];
          end else begin
            truncated_d = 1'b1;
          end
          if (cnt_q == 7'd0) src_port_d = bus.i_fifo_port;
          if (cnt_q != 7'h7f) cnt_d = cnt_q + 7'd1;
        end
        if (pending_q && bus.i_fifo_del) begin
          state_d = S_DONE;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        rden = !bus.i_fifo_empty && !pending_q;
        if (pending_q && bus.i_fifo_del) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pop issued this cycle returns its byte next cycle, regardless of empty by then
    pending_d = rden;
  end

  always_comb begin
    ram_d = ram_q;
    if (wr_en) ram_d[cnt_q[5:2]][{cnt_q[1:0], 3'b000} +: 8] = bus.i_fifo_dout;
  end

  assign iomem_hit     = bus.iomem_valid && !iomem_ready_q && (bus.iomem_addr[31:24] == 8'h06);
  assign iomem_ready_d = iomem_hit;
  assign iomem_rdata_d = iomem_hit ? ram_q[bus.iomem_addr[5:2]] : iomem_rdata_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      byte_len_q    <= '0;
      src_port_q    <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      truncated_q   <= 1'b0;
      busy_q        <= 1'b0;
      iomem_ready_q <= 1'b0;
      iomem_rdata_q <= '0;
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      byte_len_q    <= byte_len_d;
      src_port_q    <= src_port_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
      truncated_q   <= truncated_d;
      busy_q        <= busy_d;
      iomem_ready_q <= iomem_ready_d;
      iomem_rdata_q <= iomem_rdata_d;
      for (int i = 0; i < 16; i++) ram_q[i] <= ram_d[i];
    end
  end

  assign bus.o_fifo_rden = rden;
  assign bus.iomem_ready = iomem_ready_q;
  assign bus.iomem_rdata = iomem_rdata_q;

  assign cfg_do = {frame_valid_q, truncated_q, busy_q, 1'b0, src_port_q,
                   2'b00, byte_len_q, 8'h00, frame_cnt_q};

  // iomem is read-only and word-addressed; these inputs carry nothing we need
  logic unused_ok;
  assign unused_ok = ^{bus.iomem_wstrb, bus.iomem_wdata, bus.iomem_addr[23:6],
                       bus.iomem_addr[1:0], cfg_we[2:0], cfg_di[30:29], cfg_di[27:0]};

endmodule

// File: tb/tb_ctrl_frame_receiver.sv
// Directed bench for ctrl_frame_receiver: table of whole frames plus hand-written
// sequences for backpressure, flush, W1C/DONE collision and mid-frame reset.
module tb_ctrl_frame_receiver;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [3:0]  cfg_we;
  logic [31:0] cfg_di;
  logic [31:0] cfg_do;

  ctrl_frame_receiver_if bus();

  ctrl_frame_receiver dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus),
    .cfg_we (cfg_we),
    .cfg_di (cfg_di),
    .cfg_do (cfg_do)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       del;
    logic [3:0] port;
  } fent_t;

  typedef struct {
    int          len;
    logic [3:0]  port;
    logic [7:0]  base;
    bit          toggle;
    logic [31:0] exp_cfg;
  } vec_t;

  fent_t       fifo_q[$];
  logic [31:0] tb_ram [16];
  vec_t        vecs [6];
  int          n_vec = 0;
  int          n_miss = 0;
  int          underflow = 0;
  int          pop_count = 0;
  bit          toggle_en = 1'b0;
  bit          empty_force = 1'b0;
  int          tog_ctr = 0;

  // FIFO model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.o_fifo_rden) begin
      if (fifo_q.size() > 0) begin
        bus.i_fifo_dout <= fifo_q[0].data;
        bus.i_fifo_del  <= fifo_q[0].del;
        bus.i_fifo_port <= fifo_q[0].port;
        fifo_q.delete(0);
        pop_count <= pop_count + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      if (tog_ctr == 2) begin
        tog_ctr     <= 0;
        empty_force <= ~empty_force;
      end else begin
        tog_ctr <= tog_ctr + 1;
      end
    end else begin
      tog_ctr     <= 0;
      empty_force <= 1'b0;
    end
  end

  always @(negedge clk) bus.i_fifo_empty <= (fifo_q.size() == 0) || empty_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_bytes(input int n, input int start, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = start + i;
      if (idx < 64) tb_ram[idx / 4][8 * (idx % 4) +: 8] = base + 8'(idx);
    end
  endtask

  task automatic push_bytes(input int n, input int start, input logic [7:0] base,
                            input logic [3:0] port, input bit last_del, input bit model);
    for (int i = 0; i < n; i++) begin
      fent_t e;
      e.data = base + 8'(start + i);
      e.del  = last_del && (i == n - 1);
      e.port = port;
      fifo_q.push_back(e);
    end
    if (model) model_bytes(n, start, base);
  endtask

  task automatic iomem_read(input logic [31:0] addr, output logic [31:0] data);
    bit got;
    got = 1'b0;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.iomem_ready) begin
        got = 1'b1;
        break;
      end
    end
    data = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    check($sformatf("iomem_ack_%h", addr), 32'(got), 32'd1);
    tick();
    check($sformatf("iomem_ready_1cyc_%h", addr), 32'(bus.iomem_ready), 32'd0);
  endtask

  task automatic check_ram(input string tag);
    logic [31:0] d;
    for (int w = 0; w < 16; w++) begin
      iomem_read(32'h0600_0000 + 32'(w * 4), d);
      check($sformatf("%s_word%0d", tag, w), d, tb_ram[w]);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cfg_do[31]) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("%s_frame_valid", tag), 32'(ok), 32'd1);
  endtask

  task automatic cfg_write(input logic [31:0] d);
    cfg_we = 4'b1000;
    cfg_di = d;
    tick();
    cfg_we = 4'b0000;
    cfg_di = '0;
  endtask

  initial begin
    logic [31:0] d;
    int pops0;
    int seen;
    bit ok;

    vecs[0] = '{len: 6,  port: 4'b0100, base: 8'h01, toggle: 1'b0, exp_cfg: 32'h8405_0001};
    vecs[1] = '{len: 70, port: 4'b0001, base: 8'h40, toggle: 1'b0, exp_cfg: 32'hC13F_0002};
    vecs[2] = '{len: 1,  port: 4'b1000, base: 8'hA0, toggle: 1'b0, exp_cfg: 32'h8800_0003};
    vecs[3] = '{len: 13, port: 4'b0010, base: 8'h10, toggle: 1'b1, exp_cfg: 32'h820C_0004};
    vecs[4] = '{len: 64, port: 4'b0100, base: 8'hC0, toggle: 1'b0, exp_cfg: 32'h843F_0005};
    vecs[5] = '{len: 65, port: 4'b0001, base: 8'h55, toggle: 1'b1, exp_cfg: 32'hC13F_0006};

    for (int w = 0; w < 16; w++) tb_ram[w] = '0;
    cfg_we = '0;
    cfg_di = '0;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = '0;
    bus.iomem_wstrb = '0;
    bus.iomem_wdata = '0;

    repeat (3) tick();
    check("rst_cfg_do", cfg_do, 32'h0);
    check("rst_rden", 32'(bus.o_fifo_rden), 32'd0);
    check("rst_ready", 32'(bus.iomem_ready), 32'd0);
    check("rst_rdata", bus.iomem_rdata, 32'h0);
    arst_n = 1'b1;
    tick();
    check("post_rst_cfg_do", cfg_do, 32'h0);

    for (int v = 0; v < 6; v++) begin
      pops0 = pop_count;
      toggle_en = vecs[v].toggle;
      push_bytes(vecs[v].len, 0, vecs[v].base, vecs[v].port, 1'b1, 1'b1);
      wait_valid($sformatf("vec%0d", v), 3000);
      toggle_en = 1'b0;
      tick();
      tick();
      check($sformatf("vec%0d_cfg_do", v), cfg_do, vecs[v].exp_cfg);
      check($sformatf("vec%0d_popped", v), 32'(pop_count - pops0), 32'(vecs[v].len));
      check($sformatf("vec%0d_fifo_left", v), 32'(fifo_q.size()), 32'd0);
      check_ram($sformatf("vec%0d", v));
      if (v == 0) begin
        iomem_read(32'h0600_0000, d);
        check("vec0_word0_literal", d, 32'h0403_0201);
        iomem_read(32'h0600_0004, d);
        check("vec0_word1_low", {16'h0, d[15:0]}, 32'h0000_0605);
      end
      cfg_write(32'h8000_0000);
      check($sformatf("vec%0d_w1c", v), {30'h0, cfg_do[31:30]}, 32'h0);
    end

    // flush while idle changes nothing
    cfg_write(32'h1000_0000);
    tick();
    check("idle_flush_cfg_do", cfg_do, 32'h013F_0006);

    // flush after 10 of 20 bytes
    pops0 = pop_count;
    push_bytes(10, 0, 8'h30, 4'b0010, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pop_count - pops0 == 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("flush_first_half_popped", 32'(ok), 32'd1);
    repeat (3) tick();
    check("flush_busy_before", 32'(cfg_do[29]), 32'd1);
    cfg_write(32'h1000_0000);
    push_bytes(10, 10, 8'h30, 4'b0010, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!cfg_do[29]) begin
        ok = 1'b1;
        break;
      end
    end
    check("flush_busy_cleared", 32'(ok), 32'd1);
    repeat (4) tick();
    check("flush_popped", 32'(pop_count - pops0), 32'd20);
    check("flush_fifo_left", 32'(fifo_q.size()), 32'd0);
    check("flush_frame_valid", 32'(cfg_do[31]), 32'd0);
    check("flush_frame_cnt", {24'h0, cfg_do[7:0]}, 32'd6);
    check_ram("flush");

    // W1C held across DONE: the DONE set must win for exactly one cycle
    cfg_we = 4'b1000;
    cfg_di = 32'h8000_0000;
    push_bytes(3, 0, 8'hE0, 4'b1000, 1'b1, 1'b1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cfg_do[31]) seen++;
    end
    cfg_we = '0;
    cfg_di = '0;
    check("w1c_vs_done_valid_cycles", 32'(seen), 32'd1);
    tick();
    check("w1c_vs_done_cfg_do", cfg_do, 32'h0802_0007);

    // non-matching iomem address is ignored
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0700_0004;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.iomem_ready) seen++;
    end
    bus.iomem_valid = 1'b0;
    check("iomem_miss_no_ready", 32'(seen), 32'd0);

    // reset mid-frame
    push_bytes(30, 0, 8'h70, 4'b0001, 1'b1, 1'b0);
    repeat (20) tick();
    check("midrst_busy", 32'(cfg_do[29]), 32'd1);
    arst_n = 1'b0;
    #1;
    check("midrst_cfg_do", cfg_do, 32'h0);
    check("midrst_rden", 32'(bus.o_fifo_rden), 32'd0);
    check("midrst_ready", 32'(bus.iomem_ready), 32'd0);
    check("midrst_rdata", bus.iomem_rdata, 32'h0);
    fifo_q.delete();
    for (int w = 0; w < 16; w++) tb_ram[w] = '0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    check_ram("midrst");

    // second frame queued behind a valid one waits for W1C
    push_bytes(5, 0, 8'h01, 4'b0100, 1'b1, 1'b1);
    push_bytes(7, 0, 8'h90, 4'b0010, 1'b1, 1'b0);
    wait_valid("bp_first", 500);
    tick();
    check("bp_first_cfg_do", cfg_do, 32'h8404_0001);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_fifo_rden) seen++;
    end
    check("bp_no_rden", 32'(seen), 32'd0);
    check("bp_fifo_held", 32'(fifo_q.size()), 32'd7);
    check_ram("bp_first");
    model_bytes(7, 0, 8'h90);
    cfg_write(32'h8000_0000);
    wait_valid("bp_second", 500);
    tick();
    check("bp_second_cfg_do", cfg_do, 32'h8206_0002);
    check("bp_fifo_left", 32'(fifo_q.size()), 32'd0);
    check_ram("bp_second");

    check("fifo_underflow", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_receiver.md
CTRL_FRAME_RECEIVER -- requirements
Module: ctrl_frame_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock; all state on rising edge.
- arst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these control-RX FIFO ports (FIFO read latency 1 cycle):
- i_fifo_dout  in  8  frame byte, valid the cycle after o_fifo_rden.
- i_fifo_del  in  1  end-of-frame flag accompanying i_fifo_dout.
- i_fifo_port  in  4  one-hot source PHY port accompanying i_fifo_dout.
- i_fifo_empty  in  1  FIFO empty.
- o_fifo_rden  out  1  FIFO pop request.
REQ-003 The block SHALL have these picosoc iomem ports:
- iomem_valid  in  1  request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte strobes; all writes ignored.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  unused.
- iomem_rdata  out  32  read data.
REQ-004 The block SHALL have these config ports:
- cfg_we  in  4  byte write enables.
- cfg_di  in  32  write data.
- cfg_do  out  32  status/config readback.

Function
REQ-005 cfg_do SHALL be [31] frame_valid, [30] truncated, [29] busy, [28] 0, [27:24] src_port, [23:22] 0, [21:16] byte_len (bytes-1, 0..63), [15:8] 0, [7:0] frame_cnt.
REQ-006 A cfg_we[3] write with cfg_di[31]=1 SHALL clear frame_valid and truncated (write-1-to-clear); cfg_di[31]=0 SHALL leave them unchanged.
REQ-007 A cfg_we[3] write with cfg_di[28]=1 SHALL request a flush (self-clearing strobe, not stored).
REQ-008 The buffer SHALL be 16 x 32-bit RAM; byte n SHALL be stored at word n[5:2], bits [8*n[1:0]+7 : 8*n[1:0]] (little-endian).
REQ-009 The iomem port SHALL respond only when iomem_valid && !iomem_ready && iomem_addr[31:24]==8'h06, asserting iomem_ready for exactly one cycle with iomem_rdata = RAM[iomem_addr[5:2]] on the same edge.
REQ-010 The FSM SHALL have the states IDLE, RX, DROP and DONE.
REQ-011 IDLE -> RX SHALL occur when !i_fifo_empty && !frame_valid; byte counter SHALL clear and busy SHALL be set.
REQ-012 In RX/DROP, o_fifo_rden SHALL pulse only when !i_fifo_empty and no read is outstanding (at most 1 byte per 2 cycles), so no byte past i_fifo_del is ever popped.
REQ-013 Each returned byte in RX SHALL be written to RAM at the counter position; src_port SHALL be latched from the first byte.
REQ-014 The byte counter SHALL be 7-bit; a byte with counter >= 64 SHALL be discarded and set truncated, and byte_len SHALL saturate at 63.
REQ-015 A returned byte with i_fifo_del=1 in RX SHALL move the FSM to DONE; byte_len SHALL equal min(count, 64) - 1.
REQ-016 DONE SHALL last one cycle: set frame_valid, frame_cnt += 1 (8-bit wrap), clear busy, return to IDLE.
REQ-017 While frame_valid=1, the block SHALL NOT pop the FIFO (backpressure) and RAM contents SHALL be stable.
REQ-018 Flush in RX SHALL go to DROP; DROP SHALL pop and discard bytes through i_fifo_del, then go to IDLE with busy cleared, frame_valid unchanged and frame_cnt not incremented.
REQ-019 Flush in IDLE/DONE SHALL have no effect.
REQ-020 If FIFO empty occurs mid-frame, the block SHALL stall with rden low and resume without byte loss.
REQ-021 If an outstanding read returns, the byte SHALL be consumed even if i_fifo_empty has since asserted.
REQ-022 A W1C on the same edge as DONE SHALL lose to the DONE set (frame_valid=1).

Reset
REQ-023 On arst_n low the block SHALL immediately (mid-frame included) set FSM=IDLE, o_fifo_rden=0, iomem_ready=0, iomem_rdata=0, cfg_do=0, and all RAM words=0.
REQ-024 Any partial frame interrupted by reset SHALL be discarded.

Verification
REQ-025 Frame of 6 bytes 01..06 from port 4'b0100 -> word0=32'h04030201, word1[15:0]=16'h0605, cfg_do[31]=1, [27:24]=4'b0100, [21:16]=5, [7:0]=1.
REQ-026 70-byte frame -> 64 bytes stored, truncated=1, byte_len=63, all 70 popped, next frame untouched.
REQ-027 Second frame queued while frame_valid=1 -> no rden until W1C; then second frame received, frame_cnt=2.
REQ-028 Flush after 10 bytes of 20 -> remaining 10 popped, frame_valid=0, frame_cnt unchanged.
REQ-029 i_fifo_empty toggled every 3 cycles mid-frame -> data byte-exact; iomem read at 32'h0600_0004 -> word1 with single-cycle iomem_ready.
REQ-030 arst_n pulsed mid-frame -> outputs zero; next full frame received correctly.
